// File: rtl/icache_assoc.sv
// Read-only set-associative instruction cache (1 or 2 ways) with multi-word lines,
// LRU replacement, in-order burst refill, full-invalidate flush and hit/miss counters.
module icache_assoc #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SETS   = 16,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_data,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  input  logic [DATA_W-1:0] mem_req_data,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int unsigned WordW = $clog2(WORDS);
  localparam int unsigned IdxW  = $clog2(SETS);
  localparam int unsigned TagW  = ADDR_W - 2 - WordW - IdxW;

  typedef enum logic [1:0] {StIdle, StCompare, StRefill, StFlush} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WordW-1:0]    beat_q, beat_d;
  logic [IdxW-1:0]     fset_q, fset_d;
  logic                victim_q, victim_d;
  logic                refilled_q, refilled_d;
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0]     valid_q [WAYS];
  logic [SETS-1:0]     valid_d [WAYS];
  logic [SETS-1:0]     lru_q, lru_d;

  // Line payload needs no reset: valid bits alone decide whether it is ever read.
  logic [TagW-1:0]     tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0]   data_mem [WAYS][SETS][WORDS];

  logic [WordW-1:0]    req_word;
  logic [IdxW-1:0]     req_idx;
  logic [TagW-1:0]     req_tag;
  logic                hit;
  logic                hit_way;
  logic                victim_way;
  logic                ready_int;
  logic                data_we;
  logic                tag_we;
  logic                unused_addr;

  assign req_word    = addr_q[2 +: WordW];
  assign req_idx     = addr_q[2 + WordW +: IdxW];
  assign req_tag     = addr_q[ADDR_W-1 -: TagW];
  assign unused_addr = ^addr_q[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = w[0];
      end
    end
  end

  // Fill an empty way first (way 0 before way 1), otherwise evict the LRU way.
  if (WAYS == 2) begin : g_two_way
    assign victim_way = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
  end else begin : g_one_way
    assign victim_way = 1'b0;
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    beat_d         = beat_q;
    fset_d         = fset_q;
    victim_d       = victim_q;
    refilled_d     = refilled_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    valid_d        = valid_q;
    lru_d          = lru_q;
    ready_int      = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_data  = '0;
    flush_busy     = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    data_we        = 1'b0;
    tag_we         = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready_int = 1'b1;
        if (flush_req) begin
          fset_d  = '0;
          state_d = StFlush;
        end else if (cpu_req_valid) begin
          addr_d     = cpu_req_addr;
          refilled_d = 1'b0;
          state_d    = StCompare;
        end
      end

      StCompare: begin
        if (hit) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_data  = data_mem[hit_way][req_idx][req_word];
          lru_d[req_idx] = ~hit_way;
          // The compare that follows a refill was already counted as a miss.
          if (!refilled_q) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end
          state_d = StIdle;
        end else begin
          miss_cnt_d                  = miss_cnt_q + 32'd1;
          victim_d                    = victim_way;
          valid_d[victim_way][req_idx] = 1'b0;
          beat_d                      = '0;
          state_d                     = StRefill;
        end
      end

      StRefill: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_idx, beat_q, 2'b00};
        if (mem_req_ready) begin
          data_we = 1'b1;
          if (beat_q == WordW'(WORDS - 1)) begin
            tag_we                     = 1'b1;
            valid_d[victim_q][req_idx] = 1'b1;
            refilled_d                 = 1'b1;
            state_d                    = StCompare;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      StFlush: begin
        flush_busy = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          valid_d[w][fset_q] = 1'b0;
        end
        lru_d[fset_q] = 1'b0;
        if (fset_q == IdxW'(SETS - 1)) begin
          state_d = StIdle;
        end else begin
          fset_d = fset_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign cpu_req_ready = ready_int & ~rst;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      beat_q     <= '0;
      fset_q     <= '0;
      victim_q   <= 1'b0;
      refilled_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '{default: '0};
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      fset_q     <= fset_d;
      victim_q   <= victim_d;
      refilled_q <= refilled_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      lru_q      <= lru_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[victim_q][req_idx][beat_q] <= mem_req_data;
    end
    if (tag_we) begin
      tag_mem[victim_q][req_idx] <= req_tag;
    end
  end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised, read-only, set-associative instruction cache; successor to the single-word direct-mapped I-cache.
- Sits between the fetch stage (CPU side) and instruction memory (memory side).
- Adds multi-word lines, 1- or 2-way associativity with LRU replacement, burst refill, a full invalidate (flush) sequence and hit/miss counters.
- Read-only: no dirty bit, no write-back path.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, instruction word width; one word is 4 bytes.
- SETS, 16, number of sets; must be a power of 2, at least 2.
- WORDS, 4, words per line; must be a power of 2, at least 2.
- WAYS, 2, associativity; legal values are 1 and 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- cpu_req_valid  in  1  fetch request.
- cpu_req_ready  out  1  cache can accept a request.
- cpu_resp_valid  out  1  single-cycle pulse: cpu_resp_data is valid.
- cpu_resp_data  out  DATA_W  fetched instruction.
- flush_req  in  1  request to invalidate all lines.
- flush_busy  out  1  flush sweep in progress.
- mem_req_addr  out  ADDR_W  word-aligned refill address.
- mem_req_valid  out  1  refill beat request.
- mem_req_ready  in  1  memory accepts the beat; mem_req_data is valid in the same cycle.
- mem_req_data  in  DATA_W  refill data.
- hit_cnt  out  32  count of hits, wraps at 2^32.
- miss_cnt  out  32  count of misses, wraps at 2^32.

Behaviour:
- Address split: offset = [1:0]; word = next log2(WORDS) bits; index = next log2(SETS) bits; tag = the remaining upper bits.
- Per line storage: valid bit, tag, WORDS data words. Per set: one LRU bit when WAYS=2.
- Reset (asynchronous): state=IDLE; all valid and LRU bits=0; every output=0 except cpu_req_ready, which is 0 during reset and 1 in IDLE after reset. Counters=0.
- States: IDLE, COMPARE, REFILL, FLUSH.
- IDLE:
  - cpu_req_ready=1.
  - flush_req has priority: if flush_req=1, go to FLUSH, even when cpu_req_valid=1 in the same cycle (that request is not accepted).
  - Otherwise, cpu_req_valid=1 latches the address and goes to COMPARE.
- COMPARE: cpu_req_ready=0. Hit = a valid way whose tag matches the latched tag.
  - On hit: cpu_resp_valid=1 for exactly one cycle; cpu_resp_data = addressed word; LRU points to the other way; hit_cnt+1; go to IDLE.
  - Hit latency: response is 1 cycle after acceptance.
  - On miss: miss_cnt+1; choose the victim; clear the victim's valid bit; go to REFILL with beat counter=0.
  - Victim choice: first invalid way, way 0 before way 1; if both ways are valid, the LRU way. For WAYS=1 the victim is always way 0.
- REFILL:
  - mem_req_valid=1; mem_req_addr = {tag, index, beat, 2'b00}.
  - Address is held stable until mem_req_ready=1.
  - Each ready beat writes mem_req_data into victim word[beat] and increments beat.
  - On the beat where beat=WORDS-1: write tag, set valid, go to COMPARE. The re-compare hits, so no extra miss is counted.
  - Miss latency is WORDS+2 cycles with memory ready every cycle.
  - Beats are always fetched in order 0..WORDS-1; there is no critical-word-first.
- FLUSH:
  - flush_busy=1; a set counter clears the valid and LRU bits of one set per cycle.
  - After set SETS-1: go to IDLE, flush_busy=0. FLUSH lasts exactly SETS cycles.
  - flush_req arriving outside IDLE is held off until the next IDLE; the requester keeps it asserted until flush_busy is seen.
- Reset mid-refill: the refill is abandoned; the victim line is already invalid, so no partial line is ever hit.
- cpu_req_valid dropping during COMPARE or REFILL has no effect; the latched request completes.
- mem_req_ready while mem_req_valid=0 is ignored.
- Counters wrap from 0xFFFFFFFF to 0.

Test Plan:
- Cold miss, then hit. Address 0x0000_0104, memory data = address: one miss. Refill issues beats at 0x100, 0x104, 0x108, 0x10C. The response has data 0x104, miss_cnt=1. Re-fetching 0x108 gives a 1-cycle hit with data 0x108, hit_cnt=1.
- Two-way conflict. Defaults (tag starts at bit 8). Fetch 0x000, 0x100, 0x000, then 0x200. The 0x200 fill evicts the 0x100 line. Fetching 0x000 then hits; fetching 0x100 misses. miss_cnt=4.
- Memory stalls. mem_req_ready asserted every 3rd cycle during a refill: mem_req_addr is held between beats, all 4 words are stored correctly, and there is exactly one cpu_resp_valid pulse.
- Flush. Fill 3 lines, then assert flush_req together with cpu_req_valid in IDLE: flush wins, flush_busy is high for 16 cycles, and a subsequent fetch to a previously cached line misses.
- Reset in REFILL. Assert rst after beat 1 of a refill, then release: all outputs are 0, and re-fetching the same address misses and performs a full 4-beat refill.
- WAYS=1 build. Fetch 0x000, 0x100, 0x000: three misses, and way 0 is replaced each time.
